// File: rtl/linear_layer_pkg.sv
// Shared definitions for the Linear_Layer dataflow channels.
// Start-token type, default start-channel geometry, and an address-width helper.
package linear_layer_pkg;

    typedef logic start_tok_t;

    localparam int START_DEPTH      = 14;
    localparam int START_ADDR_WIDTH = 4;

    // Ceiling log2, floored at 1 so a tap address is never zero bits wide.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/start_fifo_srl_store.sv
// Uncontrolled shift-register storage: the newest entry enters slot 0 and older ones move deeper.
// The read tap is purely combinational from the registers.
module start_fifo_srl_store #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_srl [2**ADDR_WIDTH];

    // No reset on purpose: the contents are don't-care until count says otherwise.
    always_ff @(posedge clk) begin
        if (we) begin
            r_srl[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_srl[i] <= r_srl[i-1];
            end
        end
    end

    // Slots beyond DEPTH are never reached by the tap; they are tied off so nothing floats.
    for (genvar g = DEPTH; g < 2**ADDR_WIDTH; g++) begin : g_pad
        always_ff @(posedge clk) begin
            r_srl[g] <= '0;
        end
    end

    assign dout = r_srl[addr];

endmodule

// File: rtl/start_fifo_srl_ctrl.sv
// First-word-fall-through start-token FIFO built on a shift register.
// Holds the occupancy count and the registered empty/full flags; the head sits at tap count-1.
module start_fifo_srl_ctrl
    import linear_layer_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = START_ADDR_WIDTH,
    parameter int DEPTH      = START_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH_M1 = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] LP_ONE      = (ADDR_WIDTH+1)'(1);

    if (DEPTH < 2 || DEPTH > 2**ADDR_WIDTH || clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_param
        $error("start_fifo_srl_ctrl: DEPTH out of range for ADDR_WIDTH");
    end

    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty_n;
    logic                  r_full_n;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count_m1;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_wr_acc = if_write_ce & if_write & r_full_n;
    assign w_rd_acc = if_read_ce  & if_read  & r_empty_n;

    assign w_count_m1 = r_count - LP_ONE;
    assign w_addr     = (r_count == '0) ? '0 : w_count_m1[ADDR_WIDTH-1:0];

    // Simultaneous accept: the shift moves the head one slot deeper exactly as the
    // pop would move the tap one slot shallower, so count and flags simply hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else if (w_wr_acc && !w_rd_acc) begin
            r_count   <= r_count + LP_ONE;
            r_empty_n <= 1'b1;
            if (r_count == LP_DEPTH_M1) r_full_n <= 1'b0;
        end else if (w_rd_acc && !w_wr_acc) begin
            r_count  <= w_count_m1;
            r_full_n <= 1'b1;
            if (r_count == LP_ONE) r_empty_n <= 1'b0;
        end
    end

    start_fifo_srl_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_store (
        .clk  (clk),
        .we   (w_wr_acc),
        .addr (w_addr),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_empty_n = r_empty_n;
    assign if_full_n  = r_full_n;

    a_count_range : assert property (@(posedge clk) disable iff (!reset_n)
        r_count <= (ADDR_WIDTH+1)'(DEPTH));
    a_flags_track : assert property (@(posedge clk) disable iff (!reset_n)
        (r_empty_n == (r_count != '0)) && (r_full_n == (r_count != (ADDR_WIDTH+1)'(DEPTH))));

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Directed bench for start_fifo_srl_ctrl at DATA_WIDTH=8, DEPTH=14.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_start_fifo_srl_ctrl;

    localparam int DW = 8;

    logic          clk;
    logic          reset_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;

    int n_cmp;
    int n_err;

    start_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .DEPTH(14)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .if_full_n   (if_full_n),
        .if_read_ce  (if_read_ce),
        .if_read     (if_read),
        .if_dout     (if_dout),
        .if_empty_n  (if_empty_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n     = 1'b0;
        if_write_ce = 1'b1;
        if_write    = 1'b0;
        if_din      = '0;
        if_read_ce  = 1'b1;
        if_read     = 1'b0;

        // Reset held 3 cycles, then released with no traffic
        repeat (3) step();
        chk("rst_empty_n", 32'(if_empty_n), 32'd0);
        chk("rst_full_n",  32'(if_full_n),  32'd1);
        reset_n = 1'b1;
        repeat (2) step();
        chk("idle_empty_n", 32'(if_empty_n), 32'd0);
        chk("idle_full_n",  32'(if_full_n),  32'd1);

        // Fill 0x01..0x0E back-to-back
        if_write = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if_din = DW'(i);
            step();
            chk($sformatf("fill%0d_empty_n", i), 32'(if_empty_n), 32'd1);
            chk($sformatf("fill%0d_full_n", i),  32'(if_full_n),  (i < 14) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_head", i),    32'(if_dout),    32'h01);
        end
        // 15th write is dropped
        if_din = 8'hFF;
        step();
        if_write = 1'b0;
        chk("drop_full_n", 32'(if_full_n), 32'd0);
        chk("drop_head",   32'(if_dout),   32'h01);

        // Drain 14
        if_read = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            chk($sformatf("drain%0d_dout", i),    32'(if_dout),    32'(i));
            chk($sformatf("drain%0d_empty_n", i), 32'(if_empty_n), 32'd1);
            step();
        end
        if_read = 1'b0;
        chk("drained_empty_n", 32'(if_empty_n), 32'd0);
        chk("drained_full_n",  32'(if_full_n),  32'd1);

        // Simultaneous R/W at count=5
        if_write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_din = DW'(8'h10 + i);
            step();
        end
        if_read = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if_din = DW'(8'h15 + k);
            chk($sformatf("rw%0d_head", k), 32'(if_dout), 32'(8'h10 + k));
            step();
            chk($sformatf("rw%0d_empty_n", k), 32'(if_empty_n), 32'd1);
            chk($sformatf("rw%0d_full_n", k),  32'(if_full_n),  32'd1);
        end
        if_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rwdrain%0d_dout", i), 32'(if_dout),    32'(8'h24 + i));
            chk($sformatf("rwdrain%0d_empty_n", i), 32'(if_empty_n), 32'd1);
            step();
        end
        if_read = 1'b0;
        chk("rwdrained_empty_n", 32'(if_empty_n), 32'd0);

        // Write into empty with a concurrent read request: no fall-through, no pop
        if_write = 1'b1;
        if_read  = 1'b1;
        if_din   = 8'hA5;
        chk("eb_pre_empty_n", 32'(if_empty_n), 32'd0);
        step();
        if_write = 1'b0;
        chk("eb_empty_n", 32'(if_empty_n), 32'd1);
        chk("eb_dout",    32'(if_dout),    32'hA5);
        step();
        if_read = 1'b0;
        chk("eb_pop_empty_n", 32'(if_empty_n), 32'd0);

        // Write CE gating
        if_write_ce = 1'b0;
        if_write    = 1'b1;
        if_din      = 8'h99;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("wce%0d_empty_n", i), 32'(if_empty_n), 32'd0);
        end
        if_write_ce = 1'b1;
        if_din      = 8'h77;
        step();
        if_write = 1'b0;
        chk("wce_on_dout", 32'(if_dout), 32'h77);

        // Read CE gating
        if_read_ce = 1'b0;
        if_read    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rce%0d_empty_n", i), 32'(if_empty_n), 32'd1);
            chk($sformatf("rce%0d_dout", i),    32'(if_dout),    32'h77);
        end
        if_read_ce = 1'b1;
        step();
        if_read = 1'b0;
        chk("rce_on_empty_n", 32'(if_empty_n), 32'd0);

        // Reset mid-operation at count=9
        if_write = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if_din = DW'(8'h50 + i);
            step();
        end
        if_write = 1'b0;
        chk("mid_pre_empty_n", 32'(if_empty_n), 32'd1);
        chk("mid_pre_dout",    32'(if_dout),    32'h50);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_empty_n", 32'(if_empty_n), 32'd0);
        chk("mid_rst_full_n",  32'(if_full_n),  32'd1);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        if_write = 1'b1;
        if_din   = 8'h3C;
        step();
        if_write = 1'b0;
        chk("post_rst_empty_n", 32'(if_empty_n), 32'd1);
        chk("post_rst_dout",    32'(if_dout),    32'h3C);
        if_read = 1'b1;
        step();
        if_read = 1'b0;
        chk("post_rst_pop_empty_n", 32'(if_empty_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
